// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/sub pipeline.
//   fp_class_e  : operand classification after unpacking
//   sp_kind_e   : kind of special result resolved in the first stage
//   special_t   : special-result payload carried down the pipe
//   helpers     : field-width helpers and canonical quiet-NaN pattern
package fp_pkg;

    typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

    typedef enum logic [1:0] {SP_NONE, SP_QNAN, SP_INF, SP_ZERO} sp_kind_e;

    typedef struct packed {
        sp_kind_e kind;
        logic     sign;
        logic     invalid;
    } special_t;

    // guard, round and sticky bits kept below the mantissa
    localparam int GRS_BITS = 3;

    function automatic int fp_width(input int e_bits, input int m_bits);
        return 1 + e_bits + m_bits;
    endfunction

    // sign 0, exponent all ones, fraction MSB set
    function automatic logic [63:0] fp_qnan(input int e_bits, input int m_bits);
        return (((64'd1 << e_bits) - 64'd1) << m_bits) | (64'd1 << (m_bits - 1));
    endfunction

endpackage

// File: rtl/fp_add_sub_pipe_if.sv
// Handshake bundle for fp_add_sub_pipe.
//   in_valid/in_ready/a/b/op_sel : operand stream into the pipe
//   out_valid/out_ready/result/flags : result stream out of the pipe
//   master : the side feeding operands and consuming results
//   slave  : the pipe itself
interface fp_add_sub_pipe_if #(
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23
);
    localparam int WIDTH = 1 + EXP_BITS + MANT_BITS;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [2:0]       flags;

    modport master (
        output in_valid, a, b, op_sel, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, op_sel, out_ready,
        output in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter.
//   din : vector to scan, MSB first
//   cnt : number of zeros above the highest set bit (W when din is zero)
module fp_lzc #(
    parameter int W = 27,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);

    // later iterations overwrite earlier ones, so the highest set bit wins
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_add_sub_pipe.sv
// Four-stage IEEE-754 adder/subtractor with round-to-nearest-even.
//   clk, rst    : clock, synchronous active-high reset
//   io (slave)  : operands a/b with op_sel (0 add, 1 subtract) on a valid/ready
//                 input; result and flags {invalid, overflow, underflow} on a
//                 valid/ready output
// Stages: S1 unpack/classify/swap, S2 align, S3 add/sub + lzc,
// S4 normalise/round/pack. Every stage advances on one shared enable, so a
// stalled output freezes the whole pipe, bubbles included.
module fp_add_sub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23
) (
    input  logic         clk,
    input  logic         rst,
    fp_add_sub_pipe_if.slave io
);

    localparam int E     = EXP_BITS;
    localparam int M     = MANT_BITS;
    localparam int WIDTH = fp_width(E, M);
    localparam int XW    = M + 1 + GRS_BITS;   // hidden + fraction + G,R,S
    localparam int SW    = XW + 1;             // plus carry
    localparam int LW    = $clog2(XW + 1);

    localparam logic [63:0]      QNAN64   = fp_qnan(E, M);
    localparam logic [WIDTH-1:0] QNAN     = QNAN64[WIDTH-1:0];
    localparam logic [E-1:0]     EXP_ONES = '1;
    localparam logic signed [E+1:0] EXP_MAX = (E+2)'((1 << E) - 1);

    typedef struct packed {
        special_t     sp;
        logic         sign;
        logic [E-1:0] exp;
        logic         eff_sub;
        logic [M:0]   big_m;
        logic [M:0]   small_m;
        logic [E-1:0] diff;
    } s1_t;

    typedef struct packed {
        special_t      sp;
        logic          sign;
        logic [E-1:0]  exp;
        logic          eff_sub;
        logic [XW-1:0] big_x;
        logic [XW-1:0] small_x;
    } s2_t;

    typedef struct packed {
        special_t      sp;
        logic          sign;
        logic [E-1:0]  exp;
        logic [SW-1:0] sum;
        logic [LW-1:0] lzc;
    } s3_t;

    function automatic fp_class_e classify(input logic [E-1:0] e, input logic [M-1:0] f);
        if (e == '0) return FP_ZERO;
        if (e == '1) return (f == '0) ? FP_INF : FP_NAN;
        return FP_NORM;
    endfunction

    logic en;
    logic v1, v2, v3;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    s3_t  s3_d, s3_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [2:0]       flags_q;

    assign en          = !out_valid_q || io.out_ready;
    assign io.in_ready = en;
    assign io.out_valid = out_valid_q;
    assign io.result   = result_q;
    assign io.flags    = flags_q;

    // ---------------- S1: unpack, classify, swap, specials ----------------
    logic         a_s, b_s, a_big;
    logic [E-1:0] a_e, b_e;
    logic [M-1:0] a_f, b_f;
    fp_class_e    a_c, b_c;

    always_comb begin
        a_s   = io.a[WIDTH-1];
        a_e   = io.a[WIDTH-2:M];
        a_f   = io.a[M-1:0];
        b_s   = io.b[WIDTH-1] ^ io.op_sel;
        b_e   = io.b[WIDTH-2:M];
        b_f   = io.b[M-1:0];
        a_c   = classify(a_e, a_f);
        b_c   = classify(b_e, b_f);
        a_big = {a_e, a_f} >= {b_e, b_f};

        s1_d         = '0;
        s1_d.eff_sub = a_s ^ b_s;
        // a flushed subnormal contributes a zero mantissa
        if (a_big) begin
            s1_d.sign    = a_s;
            s1_d.exp     = a_e;
            s1_d.big_m   = {a_c == FP_NORM, a_f};
            s1_d.small_m = (b_c == FP_NORM) ? {1'b1, b_f} : '0;
            s1_d.diff    = a_e - b_e;
        end else begin
            s1_d.sign    = b_s;
            s1_d.exp     = b_e;
            s1_d.big_m   = {b_c == FP_NORM, b_f};
            s1_d.small_m = (a_c == FP_NORM) ? {1'b1, a_f} : '0;
            s1_d.diff    = b_e - a_e;
        end

        // x+0 with x nonzero falls through to the arithmetic path, which
        // reproduces x exactly since the small mantissa is zero
        if (a_c == FP_NAN || b_c == FP_NAN) begin
            s1_d.sp.kind = SP_QNAN;
        end else if (a_c == FP_INF && b_c == FP_INF) begin
            if (a_s != b_s) begin
                s1_d.sp.kind    = SP_QNAN;
                s1_d.sp.invalid = 1'b1;
            end else begin
                s1_d.sp.kind = SP_INF;
                s1_d.sp.sign = a_s;
            end
        end else if (a_c == FP_INF) begin
            s1_d.sp.kind = SP_INF;
            s1_d.sp.sign = a_s;
        end else if (b_c == FP_INF) begin
            s1_d.sp.kind = SP_INF;
            s1_d.sp.sign = b_s;
        end else if (a_c == FP_ZERO && b_c == FP_ZERO) begin
            s1_d.sp.kind = SP_ZERO;
            s1_d.sp.sign = a_s & b_s;
        end
    end

    // ---------------- S2: align small mantissa ----------------
    logic [XW-1:0] small_ext, lost_mask;
    logic          sticky;

    always_comb begin
        small_ext    = {s1_q.small_m, {GRS_BITS{1'b0}}};
        lost_mask    = '0;
        sticky       = 1'b0;
        s2_d.sp      = s1_q.sp;
        s2_d.sign    = s1_q.sign;
        s2_d.exp     = s1_q.exp;
        s2_d.eff_sub = s1_q.eff_sub;
        s2_d.big_x   = {s1_q.big_m, {GRS_BITS{1'b0}}};
        if (32'(s1_q.diff) >= 32'(XW - 1)) begin
            // everything lands at or below the sticky position
            s2_d.small_x = {{(XW-1){1'b0}}, |s1_q.small_m};
        end else begin
            lost_mask    = ~({XW{1'b1}} << s1_q.diff);
            sticky       = |(small_ext & lost_mask);
            s2_d.small_x = (small_ext >> s1_q.diff) | {{(XW-1){1'b0}}, sticky};
        end
    end

    // ---------------- S3: add/sub and leading-zero count ----------------
    logic [SW-1:0] sum_d;
    logic [LW-1:0] lzc_d;

    assign sum_d = s2_q.eff_sub ? ({1'b0, s2_q.big_x} - {1'b0, s2_q.small_x})
                                : ({1'b0, s2_q.big_x} + {1'b0, s2_q.small_x});

    fp_lzc #(.W(XW)) u_lzc (
        .din (sum_d[XW-1:0]),
        .cnt (lzc_d)
    );

    always_comb begin
        s3_d.sp   = s2_q.sp;
        s3_d.sign = s2_q.sign;
        s3_d.exp  = s2_q.exp;
        s3_d.sum  = sum_d;
        s3_d.lzc  = lzc_d;
    end

    // ---------------- S4: normalise, round, pack ----------------
    logic [XW-1:0]         norm;
    logic signed [E+1:0]   exp_n, exp_r;
    logic                  rnd_up;
    logic [M+1:0]          mant_r;
    logic [M-1:0]          frac_r;
    logic [WIDTH-1:0]      res_d;
    logic [2:0]            flg_d;

    always_comb begin
        if (s3_q.sum[SW-1]) begin
            // the shifted-out bit folds into sticky
            norm  = {s3_q.sum[SW-1:2], s3_q.sum[1] | s3_q.sum[0]};
            exp_n = $signed({2'b00, s3_q.exp}) + $signed((E+2)'(1));
        end else begin
            norm  = s3_q.sum[XW-1:0] << s3_q.lzc;
            exp_n = $signed({2'b00, s3_q.exp}) - $signed({{(E+2-LW){1'b0}}, s3_q.lzc});
        end

        rnd_up = norm[GRS_BITS-1] & (norm[GRS_BITS-2] | norm[0] | norm[GRS_BITS]);
        mant_r = {1'b0, norm[XW-1:GRS_BITS]} + (M+2)'(rnd_up);
        exp_r  = mant_r[M+1] ? exp_n + $signed((E+2)'(1)) : exp_n;
        frac_r = mant_r[M+1] ? mant_r[M:1] : mant_r[M-1:0];

        res_d = '0;
        flg_d = '0;
        case (s3_q.sp.kind)
            SP_QNAN: begin
                res_d = QNAN;
                flg_d = {s3_q.sp.invalid, 2'b00};
            end
            SP_INF:  res_d = {s3_q.sp.sign, EXP_ONES, {M{1'b0}}};
            SP_ZERO: res_d = {s3_q.sp.sign, {(WIDTH-1){1'b0}}};
            default: begin
                if (s3_q.sum == '0) begin
                    res_d = '0;     // exact cancellation gives +0
                end else if (!exp_r[E+1] && exp_r >= EXP_MAX) begin
                    res_d = {s3_q.sign, EXP_ONES, {M{1'b0}}};
                    flg_d = 3'b010;
                end else if (exp_r[E+1] || exp_r == '0) begin
                    res_d = {s3_q.sign, {(WIDTH-1){1'b0}}};
                    flg_d = 3'b001;
                end else begin
                    res_d = {s3_q.sign, exp_r[E-1:0], frac_r};
                end
            end
        endcase
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            v3          <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (en) begin
            v1          <= io.in_valid;
            s1_q        <= s1_d;
            v2          <= v1;
            s2_q        <= s2_d;
            v3          <= v2;
            s3_q        <= s3_d;
            out_valid_q <= v3;
            if (v3) begin
                result_q <= res_d;
                flags_q  <= flg_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Self-checking bench for fp_add_sub_pipe (binary32 configuration).
// Expected results come from an exact-integer reference model: the two
// operands are placed on a common exponent as wide integers, summed exactly,
// then rounded to nearest-even once.
module tb_fp_add_sub_pipe;

    localparam int E = 8;
    localparam int M = 23;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_add_sub_pipe_if #(.EXP_BITS(E), .MANT_BITS(M)) io ();

    fp_add_sub_pipe #(.EXP_BITS(E), .MANT_BITS(M)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic [2:0]  flg;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    int   cyc     = 0;
    int   issue_cyc = 0;
    int   ready_mode = 0;   // 0 = ready high, 1 = random, 2 = held low

    always @(posedge clk) cyc = cyc + 1;

    // ---------------- reference model ----------------
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                      input logic op, output logic [31:0] r,
                                      output logic [2:0] f);
        logic         sa, sb, sgn;
        int           ea, eb, emin, p, e, sh;
        logic [22:0]  fa, fb;
        logic [299:0] ma, mb, s, q, rem, half;
        sa = a[31];
        sb = b[31] ^ op;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        f  = 3'b000;
        r  = 32'h0;
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) begin
            r = 32'h7FC00000;
            return;
        end
        if (ea == 255 && eb == 255) begin
            if (sa != sb) begin
                r = 32'h7FC00000;
                f = 3'b100;
            end else begin
                r = {sa, 8'hFF, 23'd0};
            end
            return;
        end
        if (ea == 255) begin r = {sa, 8'hFF, 23'd0}; return; end
        if (eb == 255) begin r = {sb, 8'hFF, 23'd0}; return; end
        if (ea == 0 && eb == 0) begin r = {sa & sb, 31'd0}; return; end
        if (ea == 0) begin r = {sb, b[30:0]}; return; end
        if (eb == 0) begin r = a; return; end

        emin = (ea < eb) ? ea : eb;
        ma   = 300'({1'b1, fa}) << (ea - emin);
        mb   = 300'({1'b1, fb}) << (eb - emin);
        if (sa == sb) begin
            s = ma + mb; sgn = sa;
        end else if (ma >= mb) begin
            s = ma - mb; sgn = sa;
        end else begin
            s = mb - ma; sgn = sb;
        end
        if (s == 0) begin r = 32'h0; return; end

        p = 0;
        for (int i = 0; i < 300; i++) if (s[i]) p = i;
        e = p + emin - 23;
        if (p > 23) begin
            sh   = p - 23;
            q    = s >> sh;
            rem  = s & ((300'(1) << sh) - 300'(1));
            half = 300'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 300'(1);
            if (q[24]) begin
                q = q >> 1;
                e = e + 1;
            end
        end else begin
            q = s << (23 - p);
        end
        if (e >= 255) begin
            r = {sgn, 8'hFF, 23'd0};
            f = 3'b010;
        end else if (e <= 0) begin
            r = {sgn, 31'd0};
            f = 3'b001;
        end else begin
            r = {sgn, e[7:0], q[22:0]};
        end
    endfunction

    function automatic logic [31:0] rnd_fp();
        int          k;
        logic [7:0]  e;
        logic [22:0] f;
        logic        s;
        k = $urandom_range(0, 31);
        f = 23'($urandom);
        s = 1'($urandom);
        if (k == 0)      e = 8'h00;
        else if (k == 1) begin e = 8'hFF; f = 23'd0; end
        else if (k == 2) begin e = 8'hFF; f = f | 23'd1; end
        else if (k == 3) e = 8'd254;
        else if (k == 4) e = 8'($urandom_range(1, 4));
        else             e = 8'($urandom_range(100, 150));
        return {s, e, f};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // called at a negedge; returns at the negedge after the transfer
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op);
        int   guard;
        exp_t e;
        io.a        = a;
        io.b        = b;
        io.op_sel   = op;
        io.in_valid = 1'b1;
        guard = 0;
        while (!io.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end else begin
            issue_cyc = cyc;
            e.a = a;
            e.b = b;
            e.op = op;
            ref_model(a, b, op, e.res, e.flg);
            exp_q.push_back(e);
        end
        @(negedge clk);
        io.in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- output-ready driver ----------------
    initial begin
        io.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       io.out_ready = ($urandom_range(0, 3) != 0);
                2:       io.out_ready = 1'b0;
                default: io.out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && io.out_valid && io.out_ready) begin
                n_out++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output actual=%h required=none", io.result);
                end else begin
                    e = exp_q.pop_front();
                    if (io.result !== e.res || io.flags !== e.flg) begin
                        n_fail++;
                        $display("FAIL result a=%h b=%h op=%0d actual=%h/%b required=%h/%b",
                                 e.a, e.b, e.op, io.result, io.flags, e.res, e.flg);
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [31:0] dir_a [9] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h3F800000,
                               32'h3F800000, 32'h7F800000, 32'h7FC12345, 32'hFF800000,
                               32'h7F7FFFFF};
    logic [31:0] dir_b [9] = '{32'h40000000, 32'h3F800000, 32'h80000000, 32'h33800000,
                               32'h33800001, 32'h7F800000, 32'h3F800000, 32'h40A00000,
                               32'h7F7FFFFF};
    logic        dir_op [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int          g, cnt0;
        logic [31:0] ra, rb;
        io.in_valid = 1'b0;
        io.a        = '0;
        io.b        = '0;
        io.op_sel   = 1'b0;
        rst         = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 64'(io.out_valid), 64'd0);
        chk("reset_result", 64'(io.result), 64'd0);
        chk("reset_flags", 64'(io.flags), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // latency on an empty pipe
        send(32'h3F800000, 32'h40000000, 1'b0);
        g = 0;
        while (!io.out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("latency", 64'(cyc - issue_cyc), 64'd4);
        drain();

        // directed arithmetic, rounding, special and range cases, back to back
        for (int i = 0; i < 9; i++) send(dir_a[i], dir_b[i], dir_op[i]);
        send(32'h00800001, 32'h00800000, 1'b1);
        drain();

        // stream of 10 with a 3-cycle output stall in the middle
        cnt0 = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    ra = rnd_fp();
                    rb = ($urandom_range(0, 3) == 0) ? {ra[31:23], ra[22:0] ^ 23'($urandom_range(0, 255))}
                                                     : rnd_fp();
                    send(ra, rb, 1'($urandom));
                end
            end
            begin
                repeat (6) @(posedge clk);
                ready_mode = 2;
                @(negedge clk);
                chk("in_ready_stall", 64'(io.in_ready), 64'd0);
                repeat (3) @(posedge clk);
                ready_mode = 0;
            end
        join
        drain();
        chk("stream_count", 64'(n_out - cnt0), 64'd10);

        // longer random run with random backpressure
        cnt0 = n_out;
        ready_mode = 1;
        for (int i = 0; i < 150; i++) begin
            ra = rnd_fp();
            rb = ($urandom_range(0, 3) == 0) ? {ra[31:23], ra[22:0] ^ 23'($urandom_range(0, 255))}
                                             : rnd_fp();
            send(ra, rb, 1'($urandom));
        end
        drain();
        ready_mode = 0;
        repeat (2) @(negedge clk);
        chk("random_count", 64'(n_out - cnt0), 64'd150);

        // reset with three ops in flight
        for (int i = 0; i < 3; i++) send(rnd_fp() | 32'h3F800000, 32'h40000000, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("rst_out_valid", 64'(io.out_valid), 64'd0);
        rst = 1'b0;
        cnt0 = n_out;
        repeat (10) @(negedge clk);
        chk("rst_no_emit", 64'(n_out - cnt0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
